fusion_mac_unit: RTL and testbench
==================================

# fusion_mac_unit

Parametrised, pipelined bit-fusion multiply-accumulate engine. It takes `LANES` 8-bit operand pairs per beat, splits each operand into 2-, 4- or 8-bit elements under runtime precision control, and forms signed or unsigned element products. Products are reduced across lanes and accumulated over a group of beats into four output slots. It is the dot-product stage that sits behind the fusion multiplier datapath and feeds the output-activation path over a valid/ready handshake.

## Interface
- `LANES`, 4: number of 8-bit operand lanes per beat (≥1).
- `ACC_W`, 32: width of each accumulator slot; must be ≥ 16 + clog2(LANES).

- `clk`  in  1  clock
- `rst`  in  1  synchronous active-high reset
- `in_valid`  in  1  input beat valid
- `in_ready`  out  1  input beat accepted when `in_valid && in_ready`
- `a`  in  8*LANES  operand A; lane i is `a[8i+7:8i]`
- `b`  in  8*LANES  operand B; same lane layout
- `sa`, `sb`  in  1 each  A / B elements are two's complement when 1
- `cfga`, `cfgb`  in  2 each  element precision: 00 = 2-bit, 01 = 4-bit, 10 = 8-bit, 11 = illegal
- `acc_last`  in  1  the accepted beat closes the group
- `out_valid`  out  1  result valid
- `out_ready`  in  1  result consumed when `out_valid && out_ready`
- `out`  out  4*ACC_W  slot k is `out[ACC_W*k +: ACC_W]`
- `cfg_err`  out  1  sticky; set by a group started with an illegal config

## Operation
- **Config latch.** `sa`, `sb`, `cfga` and `cfgb` are latched on the first accepted beat of a group (accumulators empty). Values presented on later beats of the same group are ignored.
- **Element split.** pA = precision of A, pB = precision of B, pn = min(pA, pB). Each lane yields N = 8/pn products (N ∈ {1, 2, 4}). Element j of an operand occupies bits `[j*p +: p]`, with the LSB element first.
- **Pairing.**
  - Equal precision: element k of A × element k of B.
  - Unequal precision: narrow element k × wide element floor(k / (pw/pn)). Example: 8×4 gives A×B0 and A×B1; 4×2 gives A0×B0, A0×B1, A1×B2, A1×B3.
- **Product width.** Each product is exact (pA+pB bits) and is sign-extended to ACC_W if either operand is signed (sa|sb); otherwise it is zero-extended.
- **Reduction.** slot_k += Σ over lanes of product_k. Slots k ≥ N stay 0. Accumulation wraps modulo 2^ACC_W with no saturation.
- **State machine.**
  - IDLE: accumulators zero. A beat is accepted and the config is latched; go to ACCUM.
  - ACCUM: beats are accepted. Acceptance of an `acc_last` beat goes to DRAIN.
  - DRAIN: `in_ready` = 0 while the pipeline empties. `out_valid` asserts when the last beat has been accumulated; go to HOLD.
  - HOLD: `out` and `out_valid` are stable until `out_ready`. On the handshake, accumulators clear and the state returns to IDLE.
- **Single-beat group.** A beat with `acc_last` accepted in IDLE goes directly to DRAIN.
- **Illegal config.** Config 11 on either operand is processed as 10 (8-bit) and sets `cfg_err`. The flag clears only on `rst`.

## Timing
- **Reset.** `rst` has priority over everything. It clears all pipeline registers and accumulators, sets the state to IDLE, and drives `out_valid` = 0, `out` = 0, `cfg_err` = 0 and `in_ready` = 0 while asserted. `in_ready` = 1 on the first cycle after deassertion.
- **Reset mid-group** discards partial sums and any pending result. No `out_valid` follows.
- **Pipeline.** Three stages: S1 registers the lane products, S2 registers the lane sums, S3 updates the accumulators.
- **Throughput.** One beat per cycle in IDLE and ACCUM. Bubbles (`in_valid` = 0) are allowed anywhere inside a group.
- **Latency.** An `acc_last` beat accepted at edge T gives `out_valid` = 1 from edge T+3.
- **in_ready.**
  - Low from the edge after `acc_last` is accepted until the edge after the output handshake.
  - High again in the first cycle after `out_valid && out_ready`.
  - No combinational path from `out_ready` to `in_ready`.
- **out_valid.** Never deasserts without a handshake. `out` is constant while `out_valid` = 1.

## Test plan
- **8×8 signed.** LANES=4, cfga=cfgb=10, sa=sb=1, every lane a=0xFF, b=0x02, single `acc_last` beat. Expect `out_valid` at T+3, slot0 = 0xFFFFFFF8 (−8), slots 1–3 = 0.
- **4×4 unsigned.** Every lane a=0xF3, b=0x25, single beat. Expect slot0 = 60, slot1 = 120, slots 2–3 = 0.
- **8×2 mixed.** Every lane a=0x10, b=0xE4, cfga=10, cfgb=00.
  - sb=0: slots = 0, 64, 128, 192.
  - sb=1: slots = 0, 64, 0xFFFFFF80, 0xFFFFFFC0.
- **Accumulate + backpressure.** Three 8×8 unsigned beats (a=b=0x03 all lanes) with one bubble between beats. Hold `out_ready` = 0 for 5 cycles after `out_valid`. Expect slot0 = 108 held stable, `in_ready` = 0 throughout, and `in_ready` = 1 the cycle after the handshake.
- **Config latch and error.** Start a group with cfga=11, then present cfga=00 on beat 2. Expect the whole group computed as 8-bit and `cfg_err` = 1 until `rst`.
- **Reset mid-group.** Assert `rst` after two accepted beats, then run one 8×8 beat with a=b=0x01. Expect slot0 = 4 (no residue from the aborted group) and `out_valid` exactly once.

Source files
------------

// File: rtl/fusion_mac_unit.sv
// fusion_mac_unit
//   Pipelined bit-fusion multiply-accumulate engine. Each beat carries LANES
//   8-bit operand pairs. Operands are split into 2/4/8-bit elements under
//   runtime precision control, multiplied element-wise (signed or unsigned),
//   reduced across lanes and accumulated over a group of beats into four slots.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | accumulators empty; first accepted beat latches the config
//   ACCUM  | group open; beats accepted until an acc_last beat
//   DRAIN  | input blocked while the last beat flows through S1..S3
//   HOLD   | result presented on out/out_valid until out_ready
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   input beat handshake
//   a, b                LANES x 8-bit operands, lane i at [8i+7:8i]
//   sa, sb              element signedness for A / B
//   cfga, cfgb          element precision (00=2b, 01=4b, 10=8b, 11=illegal)
//   acc_last            accepted beat closes the group
//   out_valid/out_ready result handshake
//   out                 four ACC_W slots, slot k at [ACC_W*k +: ACC_W]
//   cfg_err             sticky illegal-config flag, cleared only by rst
module fusion_mac_unit #(
  parameter int LANES = 4,
  parameter int ACC_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [8*LANES-1:0]   a,
  input  logic [8*LANES-1:0]   b,
  input  logic                 sa,
  input  logic                 sb,
  input  logic [1:0]           cfga,
  input  logic [1:0]           cfgb,
  input  logic                 acc_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*ACC_W-1:0]   out,
  output logic                 cfg_err
);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DRAIN, S_HOLD} state_t;

  state_t state;

  logic       lat_sa, lat_sb;
  logic [1:0] lat_ca, lat_cb;

  logic [ACC_W-1:0] p1 [LANES][4];
  logic             v1, l1;
  logic [ACC_W-1:0] s2 [4];
  logic             v2, l2;
  logic [ACC_W-1:0] acc [4];
  logic             l3;

  logic             accept;
  logic [1:0]       ca_in, cb_in;
  logic [1:0]       eff_ca, eff_cb;
  logic             eff_sa, eff_sb;
  logic             cfg_ill;
  logic [ACC_W-1:0] prod_c [LANES][4];
  logic [ACC_W-1:0] sum_c [4];

  // Extract element idx of precision code c, sign- or zero-extended to 9 bits.
  function automatic logic signed [8:0] elem(input logic [7:0] v, input logic [1:0] c,
                                             input logic [1:0] idx, input logic s);
    logic [1:0] e2;
    logic [3:0] e4;
    e2 = v[{idx, 1'b0} +: 2];
    e4 = v[{idx[0], 2'b00} +: 4];
    case (c)
      2'd0:    elem = {{7{s & e2[1]}}, e2};
      2'd1:    elem = {{5{s & e4[3]}}, e4};
      default: elem = {s & v[7], v};
    endcase
  endfunction

  // Product k of one lane. The narrower operand supplies element k, the wider
  // one element k / (pw/pn); products beyond N = 8/pn are zero. Since the
  // elements are extended per their own signedness, the 18-bit signed product
  // is exact, and sign-extending it is a zero-extension when both are unsigned.
  function automatic logic [ACC_W-1:0] lane_prod(input logic [7:0] av, input logic [7:0] bv,
                                                 input logic [1:0] ca, input logic [1:0] cb,
                                                 input logic s_a, input logic s_b,
                                                 input logic [1:0] k);
    logic [1:0]         cn, cw, kw;
    logic [2:0]         n;
    logic signed [8:0]  ea, eb;
    logic signed [17:0] p;
    cn = (ca < cb) ? ca : cb;
    cw = (ca < cb) ? cb : ca;
    kw = k >> (cw - cn);
    n  = 3'd1 << (2'd2 - cn);
    if (ca <= cb) begin
      ea = elem(av, ca, k, s_a);
      eb = elem(bv, cb, kw, s_b);
    end else begin
      ea = elem(av, ca, kw, s_a);
      eb = elem(bv, cb, k, s_b);
    end
    p = ea * eb;
    if ({1'b0, k} < n) lane_prod = ACC_W'(p);
    else               lane_prod = '0;
  endfunction

  assign in_ready = !rst && (state == S_IDLE || state == S_ACCUM);
  assign accept   = in_valid && in_ready;

  // Illegal 11 is processed as 8-bit.
  assign ca_in   = (cfga == 2'b11) ? 2'b10 : cfga;
  assign cb_in   = (cfgb == 2'b11) ? 2'b10 : cfgb;
  assign cfg_ill = (cfga == 2'b11) || (cfgb == 2'b11);

  // The first beat of a group uses the live config; later beats the latched one.
  assign eff_ca = (state == S_IDLE) ? ca_in : lat_ca;
  assign eff_cb = (state == S_IDLE) ? cb_in : lat_cb;
  assign eff_sa = (state == S_IDLE) ? sa    : lat_sa;
  assign eff_sb = (state == S_IDLE) ? sb    : lat_sb;

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      for (int k = 0; k < 4; k++) begin
        prod_c[i][k] = lane_prod(a[8*i +: 8], b[8*i +: 8], eff_ca, eff_cb,
                                 eff_sa, eff_sb, 2'(k));
      end
    end
  end

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      sum_c[k] = '0;
      for (int i = 0; i < LANES; i++) sum_c[k] = sum_c[k] + p1[i][k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      lat_sa    <= 1'b0;
      lat_sb    <= 1'b0;
      lat_ca    <= 2'b00;
      lat_cb    <= 2'b00;
      v1        <= 1'b0;
      l1        <= 1'b0;
      v2        <= 1'b0;
      l2        <= 1'b0;
      l3        <= 1'b0;
      out_valid <= 1'b0;
      cfg_err   <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        s2[k]  <= '0;
        acc[k] <= '0;
        for (int i = 0; i < LANES; i++) p1[i][k] <= '0;
      end
    end else begin
      // S1: lane products
      v1 <= accept;
      l1 <= accept && acc_last;
      if (accept) begin
        for (int i = 0; i < LANES; i++)
          for (int k = 0; k < 4; k++) p1[i][k] <= prod_c[i][k];
      end
      // S2: lane sums
      v2 <= v1;
      l2 <= v1 && l1;
      if (v1) begin
        for (int k = 0; k < 4; k++) s2[k] <= sum_c[k];
      end
      // S3: accumulate (wraps modulo 2^ACC_W)
      l3 <= v2 && l2;
      if (v2) begin
        for (int k = 0; k < 4; k++) acc[k] <= acc[k] + s2[k];
      end

      case (state)
        S_IDLE: begin
          if (accept) begin
            lat_sa <= sa;
            lat_sb <= sb;
            lat_ca <= ca_in;
            lat_cb <= cb_in;
            if (cfg_ill) cfg_err <= 1'b1;
            state <= acc_last ? S_DRAIN : S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (accept && acc_last) state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (l3) begin
            out_valid <= 1'b1;
            state     <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            for (int k = 0; k < 4; k++) acc[k] <= '0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  for (genvar k = 0; k < 4; k++) begin : g_out
    assign out[ACC_W*k +: ACC_W] = acc[k];
  end

endmodule

// File: tb/tb_fusion_mac_unit.sv
module tb_fusion_mac_unit;
  localparam int LANES = 4;
  localparam int ACC_W = 32;

  logic                clk = 1'b0;
  logic                rst;
  logic                in_valid;
  logic                in_ready;
  logic [8*LANES-1:0]  a, b;
  logic                sa, sb;
  logic [1:0]          cfga, cfgb;
  logic                acc_last;
  logic                out_valid;
  logic                out_ready;
  logic [4*ACC_W-1:0]  out;
  logic                cfg_err;

  fusion_mac_unit #(.LANES(LANES), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sa(sa), .sb(sb), .cfga(cfga), .cfgb(cfgb),
    .acc_last(acc_last), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s actual=%h required=%h", name, act, exp);
  endtask

  // scoreboard
  logic [127:0] exp_q[$];
  int           lat_q[$];

  // reference model state
  logic [127:0] macc;
  bit           grp_open = 0;
  bit           m_sa, m_sb;
  logic [1:0]   m_ca, m_cb;
  bit           exp_err = 0;
  bit           use_ovr = 0;
  logic [127:0] ovr;
  bit           rand_rdy = 0;

  function automatic int elem_val(input logic [7:0] v, input int p, input int j, input bit s);
    int vi, raw;
    vi  = int'(v);
    raw = (vi >> (j * p)) & ((1 << p) - 1);
    if (s && raw >= (1 << (p - 1))) raw -= (1 << p);
    return raw;
  endfunction

  function automatic logic [127:0] beat_slots(input logic [31:0] av, input logic [31:0] bv,
                                              input bit s_a, input bit s_b,
                                              input logic [1:0] ca, input logic [1:0] cb);
    logic [127:0] res;
    logic [7:0]   la, lb;
    int pa, pb, pn, pw, n, r, sum, ea, eb;
    pa = (ca == 2'd3) ? 8 : (2 << ca);
    pb = (cb == 2'd3) ? 8 : (2 << cb);
    pn = (pa < pb) ? pa : pb;
    pw = (pa < pb) ? pb : pa;
    n  = 8 / pn;
    r  = pw / pn;
    res = '0;
    for (int k = 0; k < 4; k++) begin
      sum = 0;
      if (k < n) begin
        for (int l = 0; l < LANES; l++) begin
          la = av[8*l +: 8];
          lb = bv[8*l +: 8];
          if (pa <= pb) begin
            ea = elem_val(la, pa, k, s_a);
            eb = elem_val(lb, pb, k / r, s_b);
          end else begin
            ea = elem_val(la, pa, k / r, s_a);
            eb = elem_val(lb, pb, k, s_b);
          end
          sum += ea * eb;
        end
      end
      res[32*k +: 32] = sum;
    end
    return res;
  endfunction

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic set_ovr(input logic [31:0] s3, input logic [31:0] s2,
                         input logic [31:0] s1, input logic [31:0] s0);
    ovr     = {s3, s2, s1, s0};
    use_ovr = 1;
  endtask

  task automatic send(input logic [31:0] av, input logic [31:0] bv, input bit s_a, input bit s_b,
                      input logic [1:0] c_a, input logic [1:0] c_b, input bit last);
    int w;
    logic [127:0] sl;
    a = av; b = bv; sa = s_a; sb = s_b; cfga = c_a; cfgb = c_b; acc_last = last;
    in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 300) begin step(1); w++; end
    if (!in_ready) begin
      checks++;
      $display("FAIL accept_timeout actual=in_ready_low required=in_ready_high");
      in_valid = 1'b0;
      return;
    end
    step(1);
    in_valid = 1'b0;
    if (!grp_open) begin
      grp_open = 1;
      macc = '0;
      m_sa = s_a; m_sb = s_b;
      m_ca = c_a; m_cb = c_b;
      if (c_a == 2'd3 || c_b == 2'd3) exp_err = 1;
    end
    sl = beat_slots(av, bv, m_sa, m_sb, m_ca, m_cb);
    for (int k = 0; k < 4; k++) macc[32*k +: 32] = macc[32*k +: 32] + sl[32*k +: 32];
    if (last) begin
      exp_q.push_back(use_ovr ? ovr : macc);
      lat_q.push_back(cyc);
      grp_open = 0;
      use_ovr  = 0;
    end
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 500) begin step(1); w++; end
    if (exp_q.size() != 0) begin
      checks++;
      $display("FAIL drain_timeout actual=%0d pending required=0", exp_q.size());
      exp_q.delete();
      lat_q.delete();
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
  end

  // monitor
  bit prev_v = 0, prev_hs = 0;
  always @(negedge clk) begin
    if (rst) begin
      prev_v  = 0;
      prev_hs = 0;
    end else begin
      if (prev_hs) chk("in_ready_after_hs", in_ready, 1);
      if (out_valid) begin
        chk("in_ready_low_while_valid", in_ready, 0);
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL spurious_out_valid actual=%h required=no_result", out);
        end else begin
          if (!prev_v) chk("latency", cyc - lat_q[0], 3);
          chk("out_slots", out, exp_q[0]);
          if (out_ready) begin
            chk("cfg_err", cfg_err, exp_err);
            void'(exp_q.pop_front());
            void'(lat_q.pop_front());
          end
        end
      end
      prev_v  = out_valid;
      prev_hs = out_valid && out_ready;
    end
  end

  initial begin
    logic [1:0] rca, rcb;
    int nb;
    rst = 1; in_valid = 0; a = '0; b = '0; sa = 0; sb = 0; cfga = 0; cfgb = 0;
    acc_last = 0; out_ready = 1;
    step(3);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out", out, 0);
    chk("rst_cfg_err", cfg_err, 0);
    rst = 0;
    #1;
    chk("in_ready_after_rst", in_ready, 1);

    // 8x8 signed
    set_ovr(0, 0, 0, 32'hFFFF_FFF8);
    send(32'hFFFFFFFF, 32'h02020202, 1, 1, 2'd2, 2'd2, 1);
    drain();
    // 4x4 unsigned
    set_ovr(0, 0, 120, 60);
    send(32'hF3F3F3F3, 32'h25252525, 0, 0, 2'd1, 2'd1, 1);
    drain();
    // 8x2 mixed
    set_ovr(192, 128, 64, 0);
    send(32'h10101010, 32'hE4E4E4E4, 0, 0, 2'd2, 2'd0, 1);
    drain();
    set_ovr(32'hFFFF_FFC0, 32'hFFFF_FF80, 64, 0);
    send(32'h10101010, 32'hE4E4E4E4, 0, 1, 2'd2, 2'd0, 1);
    drain();

    // accumulate + backpressure
    out_ready = 0;
    send(32'h03030303, 32'h03030303, 0, 0, 2'd2, 2'd2, 0);
    step(1);
    send(32'h03030303, 32'h03030303, 0, 0, 2'd2, 2'd2, 0);
    step(1);
    set_ovr(0, 0, 0, 108);
    send(32'h03030303, 32'h03030303, 0, 0, 2'd2, 2'd2, 1);
    begin
      int w;
      w = 0;
      while (!out_valid && w < 50) begin step(1); w++; end
      if (!out_valid) begin
        checks++;
        $display("FAIL out_valid_timeout actual=0 required=1");
      end
    end
    step(5);
    out_ready = 1;
    drain();
    step(2);

    // config latch and illegal config
    send(32'h21212121, 32'h03030303, 0, 0, 2'd3, 2'd2, 0);
    set_ovr(0, 0, 0, 792);
    send(32'h21212121, 32'h03030303, 1, 1, 2'd0, 2'd0, 1);
    drain();
    send(32'h01020304, 32'h05060708, 0, 0, 2'd2, 2'd2, 1);
    drain();

    // reset mid-group
    send(32'h7F7F7F7F, 32'h11111111, 0, 0, 2'd2, 2'd2, 0);
    send(32'h7F7F7F7F, 32'h11111111, 0, 0, 2'd2, 2'd2, 0);
    rst = 1;
    grp_open = 0;
    exp_err  = 0;
    step(2);
    chk("midrst_cfg_err", cfg_err, 0);
    chk("midrst_out_valid", out_valid, 0);
    rst = 0;
    #1;
    set_ovr(0, 0, 0, 4);
    send(32'h01010101, 32'h01010101, 0, 0, 2'd2, 2'd2, 1);
    drain();
    step(8);

    // randomized groups
    rand_rdy = 1;
    for (int g = 0; g < 60; g++) begin
      nb = $urandom_range(1, 4);
      for (int j = 0; j < nb; j++) begin
        rca = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
        rcb = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
        send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             rca, rcb, j == nb - 1);
        step($urandom_range(0, 2));
      end
    end
    drain();
    rand_rdy = 0;
    out_ready = 1;
    step(5);
    chk("final_cfg_err", cfg_err, exp_err);
    chk("final_idle_out_valid", out_valid, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
